// File: rtl/count_seq_monitor.sv
// Health monitor for a free-running W-bit up-counter: locks onto a run of +1 mod 2^W steps,
// pulses tc on every observed wrap while locked, and keeps a sticky flag plus saturating fault tally.
module count_seq_monitor #(
  parameter int W           = 3,
  parameter int LOCK_CYCLES = 2,
  parameter int WRAP_W      = 8,
  parameter int ERR_W       = 4,
  parameter bit AUTO_RELOCK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [W-1:0]      count_in,
  input  logic              clr_err,
  output logic              locked,
  output logic              tc,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt
);
  localparam int RUN_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [W-1:0]     CNT_MAX = '1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_LOCKED, S_FAULT} state_t;

  state_t            state, state_n;
  logic [W-1:0]      prev, prev_n;
  logic [RUN_W-1:0]  run, run_n;
  logic              tc_n;
  logic [WRAP_W-1:0] wrap_n;
  logic              err_n;
  logic [ERR_W-1:0]  err_cnt_n;
  logic              good;
  logic              fault;

  // A held value is a stall, not a step, so only an exact +1 (with wrap) counts.
  assign good   = (count_in == prev + W'(1));
  assign locked = (state == S_LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      prev     <= '0;
      run      <= '0;
      tc       <= 1'b0;
      wrap_cnt <= '0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state    <= state_n;
      prev     <= prev_n;
      run      <= run_n;
      tc       <= tc_n;
      wrap_cnt <= wrap_n;
      err      <= err_n;
      err_cnt  <= err_cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    prev_n  = prev;
    run_n   = run;
    tc_n    = 1'b0;
    wrap_n  = wrap_cnt;
    fault   = 1'b0;
    if (!en) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          prev_n  = count_in;
          run_n   = '0;
          state_n = S_ACQUIRE;
        end
        S_ACQUIRE: begin
          prev_n = count_in;
          if (good) begin
            run_n = run + RUN_W'(1);
            if (int'(run) + 1 == LOCK_CYCLES) state_n = S_LOCKED;
          end else begin
            run_n = '0;
          end
        end
        S_LOCKED: begin
          prev_n = count_in;
          if (good) begin
            // good step out of the top value is by definition the wrap to 0
            if (prev == CNT_MAX) begin
              tc_n   = 1'b1;
              wrap_n = wrap_cnt + WRAP_W'(1);
            end
          end else begin
            fault   = 1'b1;
            run_n   = '0;
            state_n = S_FAULT;
          end
        end
        S_FAULT: begin
          if (AUTO_RELOCK || clr_err) begin
            prev_n  = count_in;
            state_n = S_ACQUIRE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // A fault arriving with clr_err restarts the tally at one instead of clearing it.
  always_comb begin
    err_n     = err;
    err_cnt_n = err_cnt;
    if (fault) begin
      err_n     = 1'b1;
      err_cnt_n = clr_err ? ERR_W'(1)
                          : ((err_cnt == ERR_MAX) ? err_cnt : err_cnt + ERR_W'(1));
    end else if (clr_err) begin
      err_n     = 1'b0;
      err_cnt_n = '0;
    end
  end

endmodule

// File: tb/tb_count_seq_monitor.sv
// Drives two monitors (auto-relock and manual-relock) with shared directed stimulus and
// checks both against a streak/resync model every cycle plus hand-computed literals.
module tb_count_seq_monitor;
  localparam int W = 3, LC = 2, WRAP_W = 8, ERR_W = 4;
  localparam int NVAL = 1 << W, MAXV = NVAL - 1, WMOD = 1 << WRAP_W, ESAT = (1 << ERR_W) - 1;

  logic clk = 1'b0;
  logic rst, en, clr_err;
  logic [W-1:0] count_in;
  logic locked_a, tc_a, err_a, locked_b, tc_b, err_b;
  logic [WRAP_W-1:0] wrap_a, wrap_b;
  logic [ERR_W-1:0] ecnt_a, ecnt_b;
  int checks = 0, errors = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  count_seq_monitor #(.W(W), .LOCK_CYCLES(LC), .WRAP_W(WRAP_W), .ERR_W(ERR_W), .AUTO_RELOCK(1'b1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .count_in(count_in), .clr_err(clr_err),
    .locked(locked_a), .tc(tc_a), .wrap_cnt(wrap_a), .err(err_a), .err_cnt(ecnt_a));

  count_seq_monitor #(.W(W), .LOCK_CYCLES(LC), .WRAP_W(WRAP_W), .ERR_W(ERR_W), .AUTO_RELOCK(1'b0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .count_in(count_in), .clr_err(clr_err),
    .locked(locked_b), .tc(tc_b), .wrap_cnt(wrap_b), .err(err_b), .err_cnt(ecnt_b));

  // Model: index 0 relocks on its own, index 1 waits for clr_err.
  bit m_sync[2], m_lk[2], m_hold[2], m_tc[2], m_err[2];
  int m_prev[2], m_streak[2], m_wrap[2], m_ecnt[2];

  task automatic model_step(input int k);
    bit fault;
    bit good;
    fault = 1'b0;
    if (rst) begin
      m_sync[k] = 0; m_lk[k] = 0; m_hold[k] = 0; m_tc[k] = 0; m_err[k] = 0;
      m_prev[k] = 0; m_streak[k] = 0; m_wrap[k] = 0; m_ecnt[k] = 0;
      return;
    end
    m_tc[k] = 1'b0;
    if (!en) begin
      m_sync[k] = 0; m_lk[k] = 0; m_hold[k] = 0; m_streak[k] = 0;
    end else if (m_hold[k]) begin
      if (k == 0 || clr_err) begin
        m_prev[k] = int'(count_in); m_sync[k] = 1; m_streak[k] = 0; m_hold[k] = 0;
      end
    end else if (!m_sync[k]) begin
      m_prev[k] = int'(count_in); m_sync[k] = 1; m_streak[k] = 0;
    end else begin
      good = (int'(count_in) == (m_prev[k] + 1) % NVAL);
      if (m_lk[k]) begin
        if (good) begin
          if (m_prev[k] == MAXV) begin
            m_tc[k] = 1'b1;
            m_wrap[k] = (m_wrap[k] + 1) % WMOD;
          end
        end else begin
          fault = 1'b1; m_lk[k] = 0; m_hold[k] = 1; m_streak[k] = 0;
        end
      end else begin
        m_streak[k] = good ? m_streak[k] + 1 : 0;
        if (m_streak[k] >= LC) m_lk[k] = 1'b1;
      end
      m_prev[k] = int'(count_in);
    end
    if (fault) begin
      m_err[k] = 1'b1;
      m_ecnt[k] = clr_err ? 1 : ((m_ecnt[k] + 1 > ESAT) ? ESAT : m_ecnt[k] + 1);
    end else if (clr_err) begin
      m_err[k] = 1'b0; m_ecnt[k] = 0;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("locked_a", locked_a, m_lk[0]);
      chk("tc_a", tc_a, m_tc[0]);
      chk("wrap_a", wrap_a, m_wrap[0]);
      chk("err_a", err_a, m_err[0]);
      chk("ecnt_a", ecnt_a, m_ecnt[0]);
      chk("locked_b", locked_b, m_lk[1]);
      chk("tc_b", tc_b, m_tc[1]);
      chk("wrap_b", wrap_b, m_wrap[1]);
      chk("err_b", err_b, m_err[1]);
      chk("ecnt_b", ecnt_b, m_ecnt[1]);
    end
  end

  // Inputs change on the falling edge; on return, outputs reflect samples up to the previous call.
  task automatic cyc(input bit r, input bit e, input int c, input bit clr);
    @(negedge clk);
    rst = r; en = e; count_in = c[W-1:0]; clr_err = clr;
  endtask

  task automatic go(input int c);
    cyc(1'b0, 1'b1, c, 1'b0);
  endtask

  int v;

  initial begin
    rst = 1'b1; en = 1'b0; count_in = '0; clr_err = 1'b0;
    cyc(1, 0, 0, 0);
    cmp_on = 1'b1;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("lit_rst_locked", locked_a, 0);
    chk("lit_rst_tc", tc_a, 0);
    chk("lit_rst_wrap", wrap_a, 0);
    chk("lit_rst_err", err_a, 0);
    chk("lit_rst_ecnt", ecnt_a, 0);

    // free-running count: lock, wrap pulses
    for (int i = 0; i <= 24; i++) begin
      go(i % NVAL);
      if (i == 2) chk("lit_prelock", locked_a, 0);
      if (i == 3) chk("lit_lock", locked_a, 1);
      if (i == 9) chk("lit_tc_first", tc_a, 1);
      if (i == 10) chk("lit_tc_pulse", tc_a, 0);
    end
    go(1);
    chk("lit_wrap3", wrap_a, 3);
    chk("lit_tc_third", tc_a, 1);
    chk("lit_noerr", err_a, 0);

    // skip 3->5
    go(2); go(3); go(5); go(6);
    chk("lit_skip_err", err_a, 1);
    chk("lit_skip_ecnt", ecnt_a, 1);
    chk("lit_skip_unlock", locked_a, 0);
    go(7); go(0); go(1);
    chk("lit_relock", locked_a, 1);
    chk("lit_relock_notc", tc_a, 0);
    chk("lit_relock_wrap", wrap_a, 3);
    chk("lit_b_hold_locked", locked_b, 0);
    chk("lit_b_hold_err", err_b, 1);

    // stall at 6
    go(2); go(3); go(4); go(5); go(6); go(6); go(6);
    chk("lit_stall_ecnt", ecnt_a, 2);
    chk("lit_stall_unlock", locked_a, 0);
    go(7); go(0); go(1);
    chk("lit_stall_relock", locked_a, 1);
    chk("lit_stall_notc", tc_a, 0);

    // 16 forced faults -> saturation
    v = 1;
    for (int i = 0; i < 16; i++) begin
      v = (v + 2) % NVAL; go(v);
      for (int j = 0; j < 3; j++) begin
        v = (v + 1) % NVAL; go(v);
      end
    end
    go(2);
    chk("lit_sat_ecnt", ecnt_a, 15);
    chk("lit_sat_err", err_a, 1);
    cyc(0, 1, 3, 1);
    go(4);
    chk("lit_clr_err", err_a, 0);
    chk("lit_clr_ecnt", ecnt_a, 0);
    chk("lit_clr_err_b", err_b, 0);
    chk("lit_clr_ecnt_b", ecnt_b, 0);
    chk("lit_clr_locked", locked_a, 1);

    // clr_err coincident with a bad step; manual-relock copy holds FAULT
    cyc(0, 1, 6, 1);
    go(7);
    chk("lit_coinc_err", err_a, 1);
    chk("lit_coinc_ecnt", ecnt_a, 1);
    chk("lit_coinc_unlock", locked_a, 0);
    go(0); go(1); go(2); go(4); go(5); go(6); go(7); go(0); go(1);
    chk("lit_t5_locked", locked_a, 1);
    chk("lit_t5_tc", tc_a, 1);
    chk("lit_t5_wrap", wrap_a, 4);
    chk("lit_t5_ecnt", ecnt_a, 2);
    chk("lit_b_locked", locked_b, 0);
    chk("lit_b_err", err_b, 1);
    chk("lit_b_ecnt", ecnt_b, 1);
    chk("lit_b_wrap", wrap_b, 3);

    // reset mid-LOCKED, then en=0 mid-LOCKED
    go(2); go(3); go(4); go(5); go(6); go(7); go(0); go(1);
    chk("lit_wrap5", wrap_a, 5);
    chk("lit_wrap5_locked", locked_a, 1);
    cyc(1, 1, 2, 0);
    go(3);
    chk("lit_rst2_locked", locked_a, 0);
    chk("lit_rst2_wrap", wrap_a, 0);
    chk("lit_rst2_err", err_a, 0);
    chk("lit_rst2_ecnt", ecnt_a, 0);
    chk("lit_rst2_err_b", err_b, 0);
    go(4); go(5); go(6);
    chk("lit_rst_relock", locked_a, 1);
    go(7); go(0); go(1);
    chk("lit_wrap_after_rst", wrap_a, 1);
    cyc(0, 0, 4, 0);
    cyc(0, 0, 2, 0);
    chk("lit_en0_unlock", locked_a, 0);
    chk("lit_en0_wrap", wrap_a, 1);
    chk("lit_en0_err", err_a, 0);
    cyc(0, 0, 7, 0);
    cyc(0, 0, 0, 0);
    chk("lit_en0_hold_wrap", wrap_a, 1);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
